fpu_host_port: RTL and testbench

FPU_HOST_PORT -- requirements
Module: fpu_host_port

---
 rtl/fpu_host_port.sv | 153 +++++++++++++++
 tb/tb_fpu_host_port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_host_port.sv
// Host-side handshake adapter: takes an operand pair from the host, sends it to an
// FPU core over stb/ack channels and holds the result until the host takes it.
module fpu_host_port #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_a,
    input  logic [31:0] i_cmd_b,

    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [31:0] o_res_data,
    output logic        o_res_timeout,
    output logic        o_busy,

    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    output logic        o_fpu_a_stb,
    output logic        o_fpu_b_stb,
    input  logic        i_fpu_a_ack,
    input  logic        i_fpu_b_ack,
    input  logic [31:0] i_fpu_z,
    input  logic        i_fpu_z_stb,
    output logic        o_fpu_z_ack
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_A   = 3'd1;
    localparam logic [2:0] SEND_B   = 3'd2;
    localparam logic [2:0] GET_Z    = 3'd3;
    localparam logic [2:0] HOLD_RES = 3'd4;

    localparam logic [31:0] ABORT_NAN  = 32'h7FC0_0000;
    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res_data;
    logic        r_res_timeout;
    logic [15:0] r_cnt;

    logic        w_phase;
    logic        w_xfer;
    logic        w_expire;

    // A transfer wins over expiry, so the abort only fires on a cycle without one.
    always_comb begin
        w_phase = (r_state == SEND_A) || (r_state == SEND_B) || (r_state == GET_Z);
        case (r_state)
            SEND_A:  w_xfer = i_fpu_a_ack;
            SEND_B:  w_xfer = i_fpu_b_ack;
            GET_Z:   w_xfer = i_fpu_z_stb;
            default: w_xfer = 1'b0;
        endcase
        w_expire = w_phase && !w_xfer && (r_cnt == LAST_CYCLE);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    w_next = SEND_A;
                end
            end
            SEND_A: begin
                if (w_xfer) begin
                    w_next = SEND_B;
                end else if (w_expire) begin
                    w_next = HOLD_RES;
                end
            end
            SEND_B: begin
                if (w_xfer) begin
                    w_next = GET_Z;
                end else if (w_expire) begin
                    w_next = HOLD_RES;
                end
            end
            GET_Z: begin
                if (w_xfer || w_expire) begin
                    w_next = HOLD_RES;
                end
            end
            HOLD_RES: begin
                if (i_res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= 32'd0;
            r_b <= 32'd0;
        end else if ((r_state == IDLE) && i_cmd_valid) begin
            r_a <= i_cmd_a;
            r_b <= i_cmd_b;
        end
    end

    // Any state change restarts the count, so each phase begins at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 16'd0;
        end else if (w_phase && !w_xfer) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data    <= 32'd0;
            r_res_timeout <= 1'b0;
        end else if ((r_state == GET_Z) && i_fpu_z_stb) begin
            r_res_data    <= i_fpu_z;
            r_res_timeout <= 1'b0;
        end else if (w_expire) begin
            r_res_data    <= ABORT_NAN;
            r_res_timeout <= 1'b1;
        end
    end

    assign o_cmd_ready   = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_res_valid   = (r_state == HOLD_RES);
    assign o_res_data    = r_res_data;
    assign o_res_timeout = r_res_timeout;
    assign o_fpu_a       = r_a;
    assign o_fpu_b       = r_b;
    assign o_fpu_a_stb   = (r_state == SEND_A);
    assign o_fpu_b_stb   = (r_state == SEND_B);
    assign o_fpu_z_ack   = (r_state == GET_Z);

endmodule

// File: tb/tb_fpu_host_port.sv
// Directed and randomized bench for fpu_host_port; a scripted FPU responder and host
// are compared against a transaction-level model of the expected result.
module tb_fpu_host_port;

    localparam int TMO = 16;
    localparam logic [31:0] NAN_WORD = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [31:0] cmdA;
    logic [31:0] cmdB;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic        resTimeout;
    logic        busy;
    logic [31:0] fpuA;
    logic [31:0] fpuB;
    logic        fpuAStb;
    logic        fpuBStb;
    logic        fpuAAck;
    logic        fpuBAck;
    logic [31:0] fpuZ;
    logic        fpuZStb;
    logic        fpuZAck;

    int checks = 0;
    int failures = 0;

    fpu_host_port #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (cmdValid),
        .o_cmd_ready  (cmdReady),
        .i_cmd_a      (cmdA),
        .i_cmd_b      (cmdB),
        .o_res_valid  (resValid),
        .i_res_ready  (resReady),
        .o_res_data   (resData),
        .o_res_timeout(resTimeout),
        .o_busy       (busy),
        .o_fpu_a      (fpuA),
        .o_fpu_b      (fpuB),
        .o_fpu_a_stb  (fpuAStb),
        .o_fpu_b_stb  (fpuBStb),
        .i_fpu_a_ack  (fpuAAck),
        .i_fpu_b_ack  (fpuBAck),
        .i_fpu_z      (fpuZ),
        .i_fpu_z_stb  (fpuZStb),
        .o_fpu_z_ack  (fpuZAck)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic stbOf(input int which);
        case (which)
            0:       return fpuAStb;
            1:       return fpuBStb;
            default: return fpuZAck;
        endcase
    endfunction

    function automatic int othersHigh(input int which);
        int n;
        n = 0;
        if (which != 0 && fpuAStb !== 1'b0) n++;
        if (which != 1 && fpuBStb !== 1'b0) n++;
        if (which != 2 && fpuZAck !== 1'b0) n++;
        return n;
    endfunction

    task automatic driveHandshake(input int which, input logic v, input logic [31:0] z);
        case (which)
            0:       fpuAAck = v;
            1:       fpuBAck = v;
            default: begin
                fpuZStb = v;
                fpuZ    = v ? z : $urandom;
            end
        endcase
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cmd_ready"}, 32'(cmdReady), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(resValid), 32'd0);
        checkOutput({tag, "_res_timeout"}, 32'(resTimeout), 32'd0);
        checkOutput({tag, "_res_data"}, resData, 32'd0);
        checkOutput({tag, "_strobes"}, {29'd0, fpuAStb, fpuBStb, fpuZAck}, 32'd0);
        checkOutput({tag, "_fpu_a"}, fpuA, 32'd0);
        checkOutput({tag, "_fpu_b"}, fpuB, 32'd0);
    endtask

    // Responder side of one phase: waits d cycles before acking; never acks if d >= TMO.
    task automatic runPhase(input int which, input int d, input logic [31:0] data,
                            output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            checkOutput($sformatf("phase%0d_stb_high", which), 32'(stbOf(which)), 32'd1);
            checkOutput($sformatf("phase%0d_exclusive", which), othersHigh(which), 32'd0);
            if (which == 0) checkOutput("fpu_a_stable", fpuA, data);
            if (which == 1) checkOutput("fpu_b_stable", fpuB, data);
            if (i == d) driveHandshake(which, 1'b1, data);
            @(negedge clk);
            driveHandshake(which, 1'b0, data);
            if (i == d) return;
        end
        aborted = 1'b1;
    endtask

    // Whole-transaction model: any phase whose responder waits TMO cycles or more aborts.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] z, input int da, input int db,
                                 input int dz, input int hs, input bit inject);
        bit ab;
        logic [31:0] expData;
        logic expTo;
        expTo   = (da >= TMO) || (db >= TMO) || (dz >= TMO);
        expData = expTo ? NAN_WORD : z;

        checkOutput("idle_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        cmdValid = 1'b1;
        cmdA     = a;
        cmdB     = b;
        @(negedge clk);
        cmdValid = 1'b0;
        cmdA     = $urandom;
        cmdB     = $urandom;
        checkOutput("accept_busy", 32'(busy), 32'd1);

        runPhase(0, da, a, ab);
        if (!ab) runPhase(1, db, b, ab);
        if (!ab) runPhase(2, dz, z, ab);

        for (int h = 0; h <= hs; h++) begin
            checkOutput("hold_res_valid", 32'(resValid), 32'd1);
            checkOutput("hold_res_data", resData, expData);
            checkOutput("hold_res_timeout", 32'(resTimeout), 32'(expTo));
            checkOutput("hold_cmd_ready", 32'(cmdReady), 32'd0);
            checkOutput("hold_strobes", {29'd0, fpuAStb, fpuBStb, fpuZAck}, 32'd0);
            if (inject && h == 0 && hs > 0) begin
                cmdValid = 1'b1;
                cmdA     = $urandom;
                cmdB     = $urandom;
            end
            if (h == hs) begin
                cmdValid = 1'b0;
                resReady = 1'b1;
            end
            @(negedge clk);
        end
        resReady = 1'b0;
        checkOutput("release_res_valid", 32'(resValid), 32'd0);
        checkOutput("release_cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("release_fpu_a_kept", fpuA, a);
        checkOutput("release_fpu_b_kept", fpuB, b);
    endtask

    initial begin
        rst      = 1'b1;
        cmdValid = 1'b0;
        cmdA     = 32'd0;
        cmdB     = 32'd0;
        resReady = 1'b0;
        fpuAAck  = 1'b0;
        fpuBAck  = 1'b0;
        fpuZ     = 32'd0;
        fpuZStb  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkReset("reset");

        $display("[TB] basic transaction");
        applyStimulus(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 0, 0, 0, 0, 1'b0);

        $display("[TB] operand a back-pressure");
        applyStimulus(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 5, 0, 2, 0, 1'b0);

        $display("[TB] host stall with ignored command");
        applyStimulus(32'h4120_0000, 32'h4170_0000, 32'h4396_0000, 1, 2, 0, 10, 1'b1);

        $display("[TB] result timeout");
        applyStimulus(32'h4248_0000, 32'h3F00_0000, 32'h1234_5678, 0, 0, 1000, 2, 1'b0);

        $display("[TB] expiry race on operand b");
        applyStimulus(32'h4080_0000, 32'h40A0_0000, 32'h41A0_0000, 0, TMO - 1, 0, 0, 1'b0);

        $display("[TB] operand b one cycle too late");
        applyStimulus(32'h4080_0000, 32'h40A0_0000, 32'h41A0_0000, 0, TMO, 0, 1, 1'b0);

        $display("[TB] reset during GET_Z");
        cmdValid = 1'b1;
        cmdA     = 32'hC000_0000;
        cmdB     = 32'h4000_0000;
        @(negedge clk);
        cmdValid = 1'b0;
        fpuAAck  = 1'b1;
        @(negedge clk);
        fpuAAck  = 1'b0;
        fpuBAck  = 1'b1;
        @(negedge clk);
        fpuBAck  = 1'b0;
        checkOutput("midz_z_ack", 32'(fpuZAck), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkReset("midz_reset");
        applyStimulus(32'h4110_0000, 32'h4000_0000, 32'h4190_0000, 0, 1, 3, 0, 1'b0);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 24; t++) begin
            applyStimulus($urandom, $urandom, $urandom,
                          $urandom_range(0, 19), $urandom_range(0, 19),
                          $urandom_range(0, 19), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
